// File: rtl/auth_driver_pkg.sv
// Shared types and constants for the USB Type-C authentication message driver.
package auth_driver_pkg;

    localparam int unsigned MSG_LEN_DEFAULT = 64;
    localparam int unsigned PEND_W          = 8;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_SEND  = 2'd2,
        ST_ERASE = 2'd3
    } state_e;

    // Requesting channel identifiers
    typedef enum logic {
        CH_PD    = 1'b0,
        CH_DEBUG = 1'b1
    } chan_e;

endpackage

// File: rtl/usb_typec_auth_driver_if.sv
// Bus bundle between the requesting channels / responder (master) and the driver (slave).
interface usb_typec_auth_driver_if #(
    parameter int unsigned MSG_LEN = auth_driver_pkg::MSG_LEN_DEFAULT
) ();

    localparam int unsigned PW = auth_driver_pkg::PEND_W;

    logic [MSG_LEN-1:0] auth_msg_in;
    logic               PD_msg_ready;
    logic               DEBUG_msg_ready;
    logic [PW-1:0]      pending_auth_request_PD;
    logic [PW-1:0]      pending_auth_request_DEBUG;
    logic               Ack_in;
    logic               PD_out_ready;
    logic               DEBUG_out_ready;
    logic [MSG_LEN-1:0] auth_msg_out;
    logic               auth_msg_ready;
    logic               pending_auth_request_PD_erase;
    logic               pending_auth_request_DEBUG_erase;

    modport master (
        output auth_msg_in, PD_msg_ready, DEBUG_msg_ready,
               pending_auth_request_PD, pending_auth_request_DEBUG,
        input  Ack_in, PD_out_ready, DEBUG_out_ready, auth_msg_out, auth_msg_ready,
               pending_auth_request_PD_erase, pending_auth_request_DEBUG_erase
    );

    modport slave (
        input  auth_msg_in, PD_msg_ready, DEBUG_msg_ready,
               pending_auth_request_PD, pending_auth_request_DEBUG,
        output Ack_in, PD_out_ready, DEBUG_out_ready, auth_msg_out, auth_msg_ready,
               pending_auth_request_PD_erase, pending_auth_request_DEBUG_erase
    );

endinterface

// File: rtl/auth_channel_arbiter.sv
// Picks which eligible channel is served. Fixed PD priority by default;
// round-robin between PD and DEBUG when ROUND_ROBIN_ARB_EN is defined.
module auth_channel_arbiter
    import auth_driver_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  elig_pd,
    input  logic  elig_debug,
    output logic  grant_valid,
    output chan_e grant_ch
);

    assign grant_valid = elig_pd | elig_debug;

`ifdef ROUND_ROBIN_ARB_EN
    chan_e last_q, last_d;

    // Remember the channel granted most recently
    always_comb begin
        last_d = last_q;
        if (grant_valid) begin
            last_d = grant_ch;
        end
    end

    // Pointer register; starts at DEBUG so PD wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= CH_DEBUG;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the channel not served last wins; a sole requester always wins
    always_comb begin
        grant_ch = CH_PD;
        if (elig_pd && elig_debug) begin
            grant_ch = (last_q == CH_PD) ? CH_DEBUG : CH_PD;
        end else if (elig_debug) begin
            grant_ch = CH_DEBUG;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    // PD has fixed priority over DEBUG
    always_comb begin
        grant_ch = CH_PD;
        if (!elig_pd && elig_debug) begin
            grant_ch = CH_DEBUG;
        end
    end
`endif

endmodule

// File: rtl/usb_typec_auth_driver.sv
// USB Type-C authentication message driver: captures one message from PD or
// DEBUG, acknowledges it, forwards it and retires the request with an erase
// strobe, at a fixed four cycles per transaction.
// Optional build macro: ROUND_ROBIN_ARB_EN (round-robin tie-break in the arbiter).
module usb_typec_auth_driver
    import auth_driver_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    usb_typec_auth_driver_if.slave bus
);

    state_e             state_q, state_d;
    chan_e              ch_q, ch_d;
    logic [MSG_LEN-1:0] msg_q, msg_d;
    logic [MSG_LEN-1:0] msg_out_q, msg_out_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               msg_rdy_q, msg_rdy_d;
    logic               erase_pd_q, erase_pd_d;
    logic               erase_dbg_q, erase_dbg_d;

    logic               accept;
    logic               elig_pd, elig_dbg;
    logic               grant_valid;
    chan_e              grant_ch;

    // Requests are taken only while the ready outputs advertise it
    assign accept   = (state_q == ST_IDLE) && ready_q;
    assign elig_pd  = accept && bus.PD_msg_ready    && (bus.pending_auth_request_PD    != '0);
    assign elig_dbg = accept && bus.DEBUG_msg_ready && (bus.pending_auth_request_DEBUG != '0);

    auth_channel_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .elig_pd     (elig_pd),
        .elig_debug  (elig_dbg),
        .grant_valid (grant_valid),
        .grant_ch    (grant_ch)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed IDLE -> ACK -> SEND -> ERASE walk once granted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_ACK;
            ST_ACK:   state_d = ST_SEND;
            ST_SEND:  state_d = ST_ERASE;
            ST_ERASE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/data next values, decoded from the next state so the registers line up with it
    always_comb begin
        ch_d        = ch_q;
        msg_d       = msg_q;
        msg_out_d   = msg_out_q;
        ready_d     = (state_d == ST_IDLE);
        ack_d       = (state_d == ST_ACK);
        msg_rdy_d   = (state_d == ST_SEND);
        erase_pd_d  = (state_d == ST_ERASE) && (ch_q == CH_PD);
        erase_dbg_d = (state_d == ST_ERASE) && (ch_q == CH_DEBUG);
        if (grant_valid) begin
            ch_d  = grant_ch;
            msg_d = bus.auth_msg_in;
        end
        if (state_d == ST_SEND) begin
            msg_out_d = msg_q;
        end
    end

    // Message, channel and output registers; reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q        <= CH_PD;
            msg_q       <= '0;
            msg_out_q   <= '0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            msg_rdy_q   <= 1'b0;
            erase_pd_q  <= 1'b0;
            erase_dbg_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            msg_q       <= msg_d;
            msg_out_q   <= msg_out_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            msg_rdy_q   <= msg_rdy_d;
            erase_pd_q  <= erase_pd_d;
            erase_dbg_q <= erase_dbg_d;
        end
    end

    assign bus.Ack_in                           = ack_q;
    assign bus.PD_out_ready                     = ready_q;
    assign bus.DEBUG_out_ready                  = ready_q;
    assign bus.auth_msg_out                     = msg_out_q;
    assign bus.auth_msg_ready                   = msg_rdy_q;
    assign bus.pending_auth_request_PD_erase    = erase_pd_q;
    assign bus.pending_auth_request_DEBUG_erase = erase_dbg_q;

endmodule

// File: tb/tb_usb_typec_auth_driver.sv
// Self-checking bench for usb_typec_auth_driver: directed scenarios plus random
// traffic, all compared against a transaction-level schedule model.
module tb_usb_typec_auth_driver;
    import auth_driver_pkg::*;

    localparam int unsigned W = 64;

`ifdef ROUND_ROBIN_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_typec_auth_driver_if #(.MSG_LEN(W)) bus ();

    usb_typec_auth_driver #(.MSG_LEN(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Model: a capture in cycle N schedules ack N+1, send N+2, erase N+3, idle N+4
    int         cyc         = 0;
    int         cap_cyc     = -100;
    int         accept_from = 0;
    logic       cap_ch      = 1'b0;
    logic [W-1:0] cap_msg   = '0;
    logic [W-1:0] exp_out   = '0;
    logic       rr_last     = 1'b1;
    logic       auto_dec    = 1'b1;
    int         n_cap[2]    = '{0, 0};
    int         n_erase[2]  = '{0, 0};
    int         n_ack_obs   = 0;
    logic       obs_order[$];
    int         n_checks    = 0;
    int         n_pass      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Advance one clock: predict the edge from current inputs, then compare outputs
    task automatic step();
        logic e_pd, e_db, win;
        logic x_ack, x_mr, x_epd, x_edb, x_rdy;
        if (reset) begin
            if (cyc <= cap_cyc + 2) n_cap[cap_ch]--;
            cap_cyc     = -100;
            accept_from = cyc + 2;
            exp_out     = '0;
            rr_last     = 1'b1;
        end else if (cyc >= accept_from) begin
            e_pd = bus.PD_msg_ready    && (bus.pending_auth_request_PD    != 8'd0);
            e_db = bus.DEBUG_msg_ready && (bus.pending_auth_request_DEBUG != 8'd0);
            if (e_pd || e_db) begin
                if (e_pd && e_db) win = RR ? ~rr_last : 1'b0;
                else              win = e_db;
                cap_cyc     = cyc;
                cap_ch      = win;
                cap_msg     = bus.auth_msg_in;
                accept_from = cyc + 4;
                rr_last     = win;
                n_cap[win]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == cap_cyc + 2) exp_out = cap_msg;
        x_ack = (cyc == cap_cyc + 1);
        x_mr  = (cyc == cap_cyc + 2);
        x_epd = (cyc == cap_cyc + 3) && !cap_ch;
        x_edb = (cyc == cap_cyc + 3) &&  cap_ch;
        x_rdy = (cyc >= accept_from);
        check_eq("ack",       64'(bus.Ack_in), 64'(x_ack));
        check_eq("msg_ready", 64'(bus.auth_msg_ready), 64'(x_mr));
        check_eq("erase_pd",  64'(bus.pending_auth_request_PD_erase), 64'(x_epd));
        check_eq("erase_dbg", 64'(bus.pending_auth_request_DEBUG_erase), 64'(x_edb));
        check_eq("pd_ready",  64'(bus.PD_out_ready), 64'(x_rdy));
        check_eq("dbg_ready", 64'(bus.DEBUG_out_ready), 64'(x_rdy));
        check_eq("msg_out",   bus.auth_msg_out, exp_out);
        check_eq("one_strobe", 64'($countones({bus.Ack_in, bus.auth_msg_ready,
                 bus.pending_auth_request_PD_erase, bus.pending_auth_request_DEBUG_erase}) <= 1), 64'd1);
        if (bus.Ack_in) n_ack_obs++;
        if (bus.pending_auth_request_PD_erase)    begin n_erase[0]++; obs_order.push_back(1'b0); end
        if (bus.pending_auth_request_DEBUG_erase) begin n_erase[1]++; obs_order.push_back(1'b1); end
        if (auto_dec && x_epd && bus.pending_auth_request_PD != 8'd0)
            bus.pending_auth_request_PD = bus.pending_auth_request_PD - 8'd1;
        if (auto_dec && x_edb && bus.pending_auth_request_DEBUG != 8'd0)
            bus.pending_auth_request_DEBUG = bus.pending_auth_request_DEBUG - 8'd1;
    endtask

    task automatic quiet();
        bus.PD_msg_ready    = 1'b0;
        bus.DEBUG_msg_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic         exp_order[3];
        int           acks0;

        reset = 1'b1;
        bus.auth_msg_in                = '0;
        bus.PD_msg_ready               = 1'b0;
        bus.DEBUG_msg_ready            = 1'b0;
        bus.pending_auth_request_PD    = 8'd0;
        bus.pending_auth_request_DEBUG = 8'd0;
        step();
        step();
        reset = 1'b0;
        step();
        step();

        // 1: single PD request with the documented latencies
        bus.pending_auth_request_PD = 8'd1;
        bus.auth_msg_in  = 64'hDEAD_BEEF_0123_4567;
        bus.PD_msg_ready = 1'b1;
        step();
        quiet();
        bus.auth_msg_in = 64'h1111_2222_3333_4444;
        check_eq("t1_ack", 64'(bus.Ack_in), 64'd1);
        step();
        check_eq("t1_out", bus.auth_msg_out, 64'hDEAD_BEEF_0123_4567);
        step();
        check_eq("t1_erase", 64'(bus.pending_auth_request_PD_erase), 64'd1);
        step();
        check_eq("t1_ready", 64'(bus.PD_out_ready), 64'd1);
        check_eq("t1_pend", 64'(bus.pending_auth_request_PD), 64'd0);

        // 2: DEBUG ready with zero pending count is ignored
        acks0 = n_ack_obs;
        bus.DEBUG_msg_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("t2_no_ack", 64'(n_ack_obs - acks0), 64'd0);
        check_eq("t2_dbg_ready", 64'(bus.DEBUG_out_ready), 64'd1);
        quiet();
        step();

        // 3: tie between PD and DEBUG, counts held at 2
        auto_dec = 1'b0;
        obs_order.delete();
        bus.pending_auth_request_PD    = 8'd2;
        bus.pending_auth_request_DEBUG = 8'd2;
        bus.PD_msg_ready    = 1'b1;
        bus.DEBUG_msg_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        quiet();
        exp_order[0] = 1'b0;
        exp_order[1] = RR;
        exp_order[2] = 1'b0;
        check_eq("t3_count", 64'(obs_order.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < obs_order.size()) check_eq($sformatf("t3_order%0d", i), 64'(obs_order[i]), 64'(exp_order[i]));
        bus.pending_auth_request_PD    = 8'd0;
        bus.pending_auth_request_DEBUG = 8'd0;
        auto_dec = 1'b1;
        step();

        // 4: reset during the SEND cycle aborts the transaction
        bus.pending_auth_request_PD = 8'd3;
        bus.auth_msg_in  = 64'hCAFE_F00D_0000_0001;
        bus.PD_msg_ready = 1'b1;
        step();
        quiet();
        step();
        check_eq("t4_send", 64'(bus.auth_msg_ready), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t4_out_zero", bus.auth_msg_out, 64'd0);
        check_eq("t4_no_erase", 64'(bus.pending_auth_request_PD_erase), 64'd0);
        step();
        check_eq("t4_pd_ready", 64'(bus.PD_out_ready), 64'd1);
        check_eq("t4_dbg_ready", 64'(bus.DEBUG_out_ready), 64'd1);
        bus.pending_auth_request_PD = 8'd0;

        // 5: input churn after capture does not disturb the forwarded message
        v = {$urandom, $urandom};
        bus.pending_auth_request_DEBUG = 8'd1;
        bus.auth_msg_in     = v;
        bus.DEBUG_msg_ready = 1'b1;
        step();
        bus.auth_msg_in = '0;
        quiet();
        step();
        check_eq("t5_hold", bus.auth_msg_out, v);
        step();
        step();

        // 6: random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.PD_msg_ready    = ($urandom_range(0, 3) != 0);
            bus.DEBUG_msg_ready = ($urandom_range(0, 3) != 0);
            bus.auth_msg_in     = {$urandom, $urandom};
            if (bus.pending_auth_request_PD == 8'd0 && $urandom_range(0, 7) == 0)
                bus.pending_auth_request_PD = 8'($urandom_range(1, 3));
            if (bus.pending_auth_request_DEBUG == 8'd0 && $urandom_range(0, 7) == 0)
                bus.pending_auth_request_DEBUG = 8'($urandom_range(1, 3));
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        quiet();
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_pd_erases",  64'(n_erase[0]), 64'(n_cap[0]));
        check_eq("t6_dbg_erases", 64'(n_erase[1]), 64'(n_cap[1]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
